// File: rtl/alu_operand_stage.sv
// alu_operand_stage: RV32I operand decode/select feeding the ALU through a 2-entry skid buffer.
// Optional build macro ALU_FWD_EN adds a single-port forwarding bypass applied to rs1/rs2 at accept.
module alu_operand_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
`ifdef ALU_FWD_EN
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [XLEN-1:0]   fwd_data,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [2:0]        alu_op,
  output logic [REG_AW-1:0] rd,
  output logic              illegal
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [2:0]        op;
    logic [REG_AW-1:0] rd;
    logic              illegal;
  } entry_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t state_reg, state_next;
  entry_t head_reg, head_next;
  entry_t skid_reg, skid_next;
  entry_t dec;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   imm_s;
  logic [REG_AW-1:0] rd_field;
  logic              legal;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign rd_field = REG_AW'(instr[11:7]);
  assign imm_i    = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s    = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

  // Operand sources: index 0 is rs1, index 1 is rs2.
  logic [XLEN-1:0] reg_data [2];
  logic [XLEN-1:0] src_data [2];

  assign reg_data[0] = rs1_data;
  assign reg_data[1] = rs2_data;

`ifdef ALU_FWD_EN
  logic [REG_AW-1:0] rs_idx [2];

  assign rs_idx[0] = REG_AW'(instr[19:15]);
  assign rs_idx[1] = REG_AW'(instr[24:20]);
`else
  logic unused_rs_field;

  assign unused_rs_field = ^instr[19:15];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ALU_FWD_EN
      // x0 is hardwired zero, so a write to it must never be forwarded.
      assign src_data[gi] = (fwd_valid && (fwd_rd != '0) && (fwd_rd == rs_idx[gi]))
                            ? fwd_data : reg_data[gi];
`else
      assign src_data[gi] = reg_data[gi];
`endif
    end
  endgenerate

  always_comb begin
    dec     = '0;
    dec.op  = OP_ADD;
    legal   = 1'b1;
    case (opcode)
      OPC_R: begin
        dec.a  = src_data[0];
        dec.b  = src_data[1];
        dec.rd = rd_field;
        case (funct3)
          3'b000:  dec.op = instr[30] ? OP_SUB : OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OPC_I: begin
        dec.a  = src_data[0];
        dec.b  = imm_i;
        dec.rd = rd_field;
        case (funct3)
          3'b000:  dec.op = OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        dec.a  = src_data[0];
        dec.b  = imm_i;
        dec.rd = rd_field;
      end
      OPC_STORE: begin
        dec.a = src_data[0];
        dec.b = imm_s;
      end
      OPC_BRANCH: begin
        dec.a  = src_data[0];
        dec.b  = src_data[1];
        dec.op = OP_SUB;
        if (funct3[2:1] != 2'b00) begin
          legal = 1'b0;
        end
      end
      default: legal = 1'b0;
    endcase
    // Unsupported encodings still flow down the pipe as a zeroed ADD marked illegal.
    if (!legal) begin
      dec         = '0;
      dec.op      = OP_ADD;
      dec.illegal = 1'b1;
    end
  end

  logic accept;
  logic pop;

  // Both handshake outputs depend only on registered occupancy.
  assign in_ready  = (state_reg != S_TWO);
  assign out_valid = (state_reg != S_EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    case (state_reg)
      S_EMPTY: begin
        if (accept) begin
          head_next  = dec;
          state_next = S_ONE;
        end
      end
      S_ONE: begin
        if (accept && !pop) begin
          skid_next  = dec;
          state_next = S_TWO;
        end else if (accept && pop) begin
          head_next  = dec;
        end else if (pop) begin
          state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (pop) begin
          head_next  = skid_reg;
          state_next = S_ONE;
        end
      end
      default: state_next = S_EMPTY;
    endcase
    if (flush) begin
      state_next = S_EMPTY;
      head_next  = head_reg;
      skid_next  = skid_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      skid_reg  <= skid_next;
    end
  end

  assign alu_a   = head_reg.a;
  assign alu_b   = head_reg.b;
  assign alu_op  = head_reg.op;
  assign rd      = head_reg.rd;
  assign illegal = head_reg.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed-vector bench for alu_operand_stage (decode, buffering, flush, reset).
// Build with ALU_FWD_EN defined to also exercise the forwarding bypass.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  rd;
  logic        illegal;
`ifdef ALU_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
`ifdef ALU_FWD_EN
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .rd        (rd),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction through an idle stage with out_ready=1: appears after one edge, gone after the next.
  task automatic issue(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [2:0] e_op, input logic [31:0] e_a,
                       input logic [31:0] e_b, input logic [4:0] e_rd, input logic e_ill);
    instr    = ins;
    rs1_data = r1;
    rs2_data = r2;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".op"}, 32'(alu_op), 32'(e_op));
    chk({tag, ".a"}, alu_a, e_a);
    chk({tag, ".b"}, alu_b, e_b);
    chk({tag, ".rd"}, 32'(rd), 32'(e_rd));
    chk({tag, ".ill"}, 32'(illegal), 32'(e_ill));
    $display("txn %-8s instr=%08h op=%03b a=%08h b=%08h rd=%0d ill=%0b",
             tag, ins, alu_op, alu_a, alu_b, rd, illegal);
    tick();
    chk({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  // Present an add with the given rs1 value; used where only ordering matters.
  task automatic drive_add(input logic [31:0] r1);
    instr    = 32'h002081B3;
    rs1_data = r1;
    rs2_data = 32'd7;
    in_valid = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h002081B3;
    rs1_data  = 32'd5;
    rs2_data  = 32'd7;
    out_ready = 1'b0;
`ifdef ALU_FWD_EN
    fwd_valid = 1'b0;
    fwd_rd    = 5'd0;
    fwd_data  = 32'd0;
`endif

    // Reset with input pending
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.a", alu_a, 32'd0);
    chk("rst.b", alu_b, 32'd0);
    chk("rst.op", 32'(alu_op), 32'd0);
    chk("rst.rd", 32'(rd), 32'd0);
    chk("rst.ill", 32'(illegal), 32'd0);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();

    // Decode vectors
    issue("add",  32'h002081B3, 32'd5,     32'd7,    3'b010, 32'd5,     32'd7,        5'd3, 1'b0);
    issue("sub",  32'h402081B3, 32'd5,     32'd7,    3'b110, 32'd5,     32'd7,        5'd3, 1'b0);
    issue("and",  32'h0020F1B3, 32'hF0,    32'h3C,   3'b000, 32'hF0,    32'h3C,       5'd3, 1'b0);
    issue("or",   32'h0020E1B3, 32'h1,     32'h2,    3'b001, 32'h1,     32'h2,        5'd3, 1'b0);
    issue("slt",  32'h0020A1B3, 32'h9,     32'hA,    3'b111, 32'h9,     32'hA,        5'd3, 1'b0);
    issue("addi", 32'hFFF00093, 32'h10,    32'h20,   3'b010, 32'h10,    32'hFFFFFFFF, 5'd1, 1'b0);
    issue("lw",   32'hFFC0A283, 32'h1000,  32'h0,    3'b010, 32'h1000,  32'hFFFFFFFC, 5'd5, 1'b0);
    issue("sw",   32'h0020A223, 32'h100,   32'h55,   3'b010, 32'h100,   32'd4,        5'd0, 1'b0);
    issue("beq",  32'h00208063, 32'h33,    32'h44,   3'b110, 32'h33,    32'h44,       5'd0, 1'b0);
    issue("opc7f", 32'h0000007F, 32'd5,    32'd7,    3'b010, 32'd0,     32'd0,        5'd0, 1'b1);
    issue("sll",  32'h002091B3, 32'd5,     32'd7,    3'b010, 32'd0,     32'd0,        5'd0, 1'b1);

    // Backpressure: three back-to-back, only two accepted
    out_ready = 1'b0;
    drive_add(32'h11);
    tick();
    chk("bp.rdy1", 32'(in_ready), 32'd1);
    drive_add(32'h22);
    tick();
    chk("bp.rdy2", 32'(in_ready), 32'd0);
    drive_add(32'h33);
    tick();
    chk("bp.rdy3", 32'(in_ready), 32'd0);
    chk("bp.head", alu_a, 32'h11);
    in_valid = 1'b0;
    tick();
    chk("bp.hold", alu_a, 32'h11);
    chk("bp.hold_v", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp.second", alu_a, 32'h22);
    chk("bp.rdy_pop", 32'(in_ready), 32'd1);
    $display("txn bp       popped a=%08h", alu_a);
    tick();
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Flush while full with a pending accept
    out_ready = 1'b0;
    drive_add(32'h44);
    tick();
    drive_add(32'h55);
    tick();
    drive_add(32'h66);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 32'(out_valid), 32'd0);
    chk("fl.rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fl.gone", 32'(out_valid), 32'd0);
    end
    drive_add(32'h77);
    tick();
    in_valid = 1'b0;
    chk("fl.next", alu_a, 32'h77);
    $display("txn flush    next a=%08h", alu_a);
    tick();

    // Throughput: one in, one out per cycle
    for (int i = 0; i < 10; i++) begin
      drive_add(32'h100 + 32'(i));
      tick();
      chk("tp.rdy", 32'(in_ready), 32'd1);
      chk("tp.valid", 32'(out_valid), 32'd1);
      chk("tp.a", alu_a, 32'h100 + 32'(i));
      $display("txn tp%0d     a=%08h", i, alu_a);
    end
    in_valid = 1'b0;
    tick();
    chk("tp.drain", 32'(out_valid), 32'd0);

    // Reset mid-transfer while full, asserted together with flush
    out_ready = 1'b0;
    drive_add(32'h88);
    tick();
    drive_add(32'h99);
    tick();
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("rst2.valid", 32'(out_valid), 32'd0);
    chk("rst2.rdy", 32'(in_ready), 32'd1);
    chk("rst2.a", alu_a, 32'd0);
    chk("rst2.op", 32'(alu_op), 32'd0);
    out_ready = 1'b1;
    tick();

`ifdef ALU_FWD_EN
    fwd_valid = 1'b1;
    fwd_rd    = 5'd1;
    fwd_data  = 32'h99;
    issue("fwd11", 32'h001081B3, 32'd5, 32'd7, 3'b010, 32'h99, 32'h99, 5'd3, 1'b0);
    fwd_rd = 5'd2;
    issue("fwd2", 32'h002081B3, 32'd5, 32'd7, 3'b010, 32'd5, 32'h99, 5'd3, 1'b0);
    fwd_rd = 5'd0;
    issue("fwd0", 32'h001081B3, 32'd5, 32'd7, 3'b010, 32'd5, 32'd7, 5'd3, 1'b0);
    fwd_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
